// File: rtl/press_classifier.sv
// Button press classifier: turns debounced rise/fall pulses into short, long and double press events.
// Define PRESS_CLASSIFIER_DOUBLE_PRESS_EN to build the double-press path (WAIT_GAP and SECOND states).
module press_classifier #(
    parameter int LONG_COUNT = 50_000_000,
    parameter int GAP_COUNT  = 12_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       level,
    input  logic       rise,
    input  logic       fall,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       held,
    output logic [7:0] event_count
);

    localparam int MAX_COUNT = (LONG_COUNT > GAP_COUNT) ? LONG_COUNT : GAP_COUNT;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_COUNT - 1);
    localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRESSED   = 3'd1;
    localparam logic [2:0] ST_LONG_HELD = 3'd2;
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    localparam logic [2:0] ST_WAIT_GAP  = 3'd3;
    localparam logic [2:0] ST_SECOND    = 3'd4;
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_COUNT - 1);
`endif

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          short_reg, short_next;
    logic          long_reg, long_next;
    logic          held_reg;
    logic [7:0]    event_count_reg, event_count_next;
    logic          rise_ok, fall_ok;
    logic          counting;
    logic          pulse_any;
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    logic          double_reg, double_next;
`endif

    // A coincident rise and fall is contradictory, so both are dropped.
    assign rise_ok = rise & ~fall;
    assign fall_ok = fall & ~rise;

    always_comb begin
        state_next = state_reg;
        short_next = 1'b0;
        long_next  = 1'b0;
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
        double_next = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (rise_ok) state_next = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (fall_ok) begin
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
                    state_next = ST_WAIT_GAP;
`else
                    state_next = ST_IDLE;
                    short_next = 1'b1;
`endif
                end else if (level && count_reg == LONG_LAST) begin
                    state_next = ST_LONG_HELD;
                    long_next  = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (fall_ok) state_next = ST_IDLE;
            end
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
            ST_WAIT_GAP: begin
                if (rise_ok) begin
                    state_next = ST_SECOND;
                end else if (count_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                    short_next = 1'b1;
                end
            end
            ST_SECOND: begin
                // A second press held long replaces the pending double with a long press.
                if (fall_ok) begin
                    state_next  = ST_IDLE;
                    double_next = 1'b1;
                end else if (level && count_reg == LONG_LAST) begin
                    state_next = ST_LONG_HELD;
                    long_next  = 1'b1;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
        counting  = (state_reg == ST_PRESSED) || (state_reg == ST_WAIT_GAP) || (state_reg == ST_SECOND);
        pulse_any = short_next | long_next | double_next;
`else
        counting  = (state_reg == ST_PRESSED);
        pulse_any = short_next | long_next;
`endif
        // Saturate rather than wrap when a press lingers without a decision (level low).
        if (state_next != state_reg) begin
            count_next = '0;
        end else if (counting && count_reg != CNT_SAT) begin
            count_next = count_reg + CW'(1);
        end else begin
            count_next = count_reg;
        end
        event_count_next = pulse_any ? event_count_reg + 8'd1 : event_count_reg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            count_reg       <= '0;
            short_reg       <= 1'b0;
            long_reg        <= 1'b0;
            held_reg        <= 1'b0;
            event_count_reg <= 8'd0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            short_reg       <= short_next;
            long_reg        <= long_next;
            held_reg        <= (state_next == ST_LONG_HELD);
            event_count_reg <= event_count_next;
        end
    end

`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            double_reg <= 1'b0;
        end else begin
            double_reg <= double_next;
        end
    end
    assign double_press = double_reg;
`else
    assign double_press = 1'b0;
`endif

    assign short_press = short_reg;
    assign long_press  = long_reg;
    assign held        = held_reg;
    assign event_count = event_count_reg;

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier with a timestamp-based reference model.
// Follows PRESS_CLASSIFIER_DOUBLE_PRESS_EN the same way the design does.
module tb_press_classifier;

    localparam int LONG_COUNT = 8;
    localparam int GAP_COUNT  = 4;
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    localparam int SHORT_DELAY = GAP_COUNT;
`else
    localparam int SHORT_DELAY = 0;
`endif

    localparam int PH_IDLE   = 0;
    localparam int PH_DOWN   = 1;
    localparam int PH_LONG   = 2;
    localparam int PH_GAP    = 3;
    localparam int PH_SECOND = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       level = 1'b0;
    logic       rise  = 1'b0;
    logic       fall  = 1'b0;
    logic       short_press, long_press, double_press, held;
    logic [7:0] event_count;

    int checks = 0;
    int errors = 0;

    // Reference model: press phase plus edge timestamps of the deciding events.
    int   m_phase, m_n, m_t_press, m_t_release, m_t_second, m_count;
    logic m_short, m_long, m_double, m_held;
    logic cur_level = 1'b0;

    press_classifier #(.LONG_COUNT(LONG_COUNT), .GAP_COUNT(GAP_COUNT)) dut (
        .clock(clock), .reset(reset), .level(level), .rise(rise), .fall(fall),
        .short_press(short_press), .long_press(long_press), .double_press(double_press),
        .held(held), .event_count(event_count)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] outs();
        return {short_press, long_press, double_press, held, event_count};
    endfunction

    function automatic logic [11:0] exp_vec();
        return {m_short, m_long, m_double, m_held, 8'(m_count)};
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_n = 0; m_count = 0;
        m_t_press = 0; m_t_release = 0; m_t_second = 0;
        m_short = 0; m_long = 0; m_double = 0; m_held = 0;
    endtask

    task automatic model_edge(input logic r, input logic f, input logic lv);
        logic rr, ff;
        rr = r & ~f;
        ff = f & ~r;
        m_n++;
        m_short = 0; m_long = 0; m_double = 0;
        case (m_phase)
            PH_IDLE: if (rr) begin m_phase = PH_DOWN; m_t_press = m_n; end
            PH_DOWN: begin
                if (ff) begin
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
                    m_phase = PH_GAP; m_t_release = m_n;
`else
                    m_phase = PH_IDLE; m_short = 1;
`endif
                end else if (lv && (m_n - m_t_press) == LONG_COUNT) begin
                    m_phase = PH_LONG; m_long = 1;
                end
            end
            PH_LONG: if (ff) m_phase = PH_IDLE;
            PH_GAP: begin
                if (rr) begin m_phase = PH_SECOND; m_t_second = m_n; end
                else if ((m_n - m_t_release) == GAP_COUNT) begin m_phase = PH_IDLE; m_short = 1; end
            end
            PH_SECOND: begin
                if (ff) begin m_phase = PH_IDLE; m_double = 1; end
                else if (lv && (m_n - m_t_second) == LONG_COUNT) begin m_phase = PH_LONG; m_long = 1; end
            end
            default: m_phase = PH_IDLE;
        endcase
        if (m_short || m_long || m_double) m_count = (m_count + 1) % 256;
        m_held = (m_phase == PH_LONG);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input logic r, input logic f, input logic lv);
        rise = r; fall = f; level = lv; cur_level = lv;
        @(posedge clock);
        model_edge(r, f, lv);
        @(negedge clock);
        rise = 1'b0; fall = 1'b0;
    endtask

    task automatic sync_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        level = 1'b0; cur_level = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (outs() !== 12'h000) begin errors++; $display("FAIL reset_state: got %h expected 000", outs()); end
        rise = 1'b1; level = 1'b1;
        @(negedge clock);
        checks++;
        if (outs() !== 12'h000) begin errors++; $display("FAIL reset_ignores_clock: got %h expected 000", outs()); end
        rise = 1'b0; level = 1'b0;
        reset = 1'b0;
        model_reset();
        drive(0, 0, 0);
        checks++;
        if (outs() !== exp_vec()) begin errors++; $display("FAIL reset_release: got %h expected %h", outs(), exp_vec()); end
        $display("test_reset done");
    endtask

    task automatic test_short();
        int n_short = 0, k_short = -1, n_other = 0;
        drive(1, 0, 1); drive(0, 0, 1); drive(0, 0, 1);
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) drive(0, 1, 0); else drive(0, 0, 0);
            if (short_press) begin n_short++; k_short = k; end
            if (long_press || double_press) n_other++;
        end
        checks++;
        if (n_short !== 1) begin errors++; $display("FAIL short_count: got %0d expected 1", n_short); end
        checks++;
        if (k_short !== SHORT_DELAY) begin errors++; $display("FAIL short_delay: got %0d expected %0d", k_short, SHORT_DELAY); end
        checks++;
        if (n_other !== 0) begin errors++; $display("FAIL short_other_pulses: got %0d expected 0", n_other); end
        checks++;
        if (event_count !== 8'd1) begin errors++; $display("FAIL short_event_count: got %0d expected 1", event_count); end
        $display("test_short done");
    endtask

    task automatic test_long();
        int n_long = 0, k_long = -1, n_held = 0, n_other = 0;
        drive(1, 0, 1);
        for (int j = 1; j <= 10; j++) begin
            drive(0, 0, 1);
            if (long_press) begin n_long++; k_long = j; end
            if (held) n_held++;
            if (short_press || double_press) n_other++;
        end
        drive(0, 1, 0);
        checks++;
        if (held !== 1'b0) begin errors++; $display("FAIL long_held_after_fall: got %b expected 0", held); end
        for (int j = 0; j < 6; j++) begin
            drive(0, 0, 0);
            if (short_press || double_press || long_press) n_other++;
        end
        checks++;
        if (n_long !== 1) begin errors++; $display("FAIL long_count: got %0d expected 1", n_long); end
        checks++;
        if (k_long !== LONG_COUNT) begin errors++; $display("FAIL long_delay: got %0d expected %0d", k_long, LONG_COUNT); end
        checks++;
        if (n_held !== 3) begin errors++; $display("FAIL long_held_cycles: got %0d expected 3", n_held); end
        checks++;
        if (n_other !== 0) begin errors++; $display("FAIL long_other_pulses: got %0d expected 0", n_other); end
        checks++;
        if (event_count !== 8'(m_count)) begin errors++; $display("FAIL long_event_count: got %0d expected %0d", event_count, m_count); end
        $display("test_long done");
    endtask

`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    task automatic test_double();
        logic [2:0] seq [13] = '{3'b101, 3'b001, 3'b010, 3'b000, 3'b101, 3'b001, 3'b010,
                                 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        int n_double = 0, k_double = -1, n_other = 0;
        for (int i = 0; i < 13; i++) begin
            drive(seq[i][2], seq[i][1], seq[i][0]);
            if (double_press) begin n_double++; k_double = i; end
            if (short_press || long_press) n_other++;
        end
        checks++;
        if (n_double !== 1) begin errors++; $display("FAIL double_count: got %0d expected 1", n_double); end
        checks++;
        if (k_double !== 6) begin errors++; $display("FAIL double_timing: got step %0d expected 6", k_double); end
        checks++;
        if (n_other !== 0) begin errors++; $display("FAIL double_other_pulses: got %0d expected 0", n_other); end
        checks++;
        if (event_count !== 8'(m_count)) begin errors++; $display("FAIL double_event_count: got %0d expected %0d", event_count, m_count); end
        $display("test_double done");
    endtask
`else
    task automatic test_no_double();
        logic [2:0] seq [13] = '{3'b101, 3'b001, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000,
                                 3'b101, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
        int n_double = 0, n_short = 0, k_first = -1;
        for (int i = 0; i < 13; i++) begin
            drive(seq[i][2], seq[i][1], seq[i][0]);
            if (double_press) n_double++;
            if (short_press) begin
                if (n_short == 0) k_first = i;
                n_short++;
            end
        end
        checks++;
        if (n_double !== 0) begin errors++; $display("FAIL no_double_pulses: got %0d expected 0", n_double); end
        checks++;
        if (n_short !== 2) begin errors++; $display("FAIL no_double_shorts: got %0d expected 2", n_short); end
        checks++;
        if (k_first !== 3) begin errors++; $display("FAIL no_double_short_timing: got step %0d expected 3", k_first); end
        checks++;
        if (event_count !== 8'(m_count)) begin errors++; $display("FAIL no_double_event_count: got %0d expected %0d", event_count, m_count); end
        $display("test_no_double done");
    endtask
`endif

    task automatic test_reset_mid_press();
        int n_pulse = 0, n_short = 0;
        drive(1, 0, 1);
        repeat (5) drive(0, 0, 1);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (outs() !== 12'h000) begin errors++; $display("FAIL reset_mid_async: got %h expected 000", outs()); end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int j = 0; j < 12; j++) begin
            drive(0, 0, 1);
            if (short_press || long_press || double_press || held) n_pulse++;
        end
        drive(0, 1, 0);
        if (short_press || long_press || double_press || held) n_pulse++;
        checks++;
        if (n_pulse !== 0) begin errors++; $display("FAIL reset_mid_no_pulse: got %0d expected 0", n_pulse); end
        drive(1, 0, 1); drive(0, 0, 1); drive(0, 0, 1); drive(0, 1, 0);
        if (short_press) n_short++;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0);
            if (short_press) n_short++;
        end
        checks++;
        if (n_short !== 1) begin errors++; $display("FAIL reset_mid_next_short: got %0d expected 1", n_short); end
        checks++;
        if (event_count !== 8'd1) begin errors++; $display("FAIL reset_mid_event_count: got %0d expected 1", event_count); end
        $display("test_reset_mid_press done");
    endtask

    task automatic test_wrap();
        int n_short = 0;
        sync_reset();
        for (int p = 1; p <= 256; p++) begin
            drive(1, 0, 1); drive(0, 0, 1); drive(0, 0, 1); drive(0, 1, 0);
            if (short_press) n_short++;
            for (int k = 0; k < 5; k++) begin
                drive(0, 0, 0);
                if (short_press) n_short++;
            end
            if (p == 255) begin
                checks++;
                if (event_count !== 8'd255) begin errors++; $display("FAIL wrap_count_255: got %0d expected 255", event_count); end
            end
        end
        checks++;
        if (n_short !== 256) begin errors++; $display("FAIL wrap_short_total: got %0d expected 256", n_short); end
        checks++;
        if (event_count !== 8'd0) begin errors++; $display("FAIL wrap_count_0: got %0d expected 0", event_count); end
        $display("test_wrap done");
    endtask

    task automatic test_random();
        logic r, f, lv;
        int sel;
        sync_reset();
        for (int c = 0; c < 4000; c++) begin
            r = 1'b0; f = 1'b0; lv = cur_level;
            sel = $urandom_range(0, 99);
            if (sel < 18) begin
                lv = ~cur_level;
                if (lv) r = 1'b1; else f = 1'b1;
            end else if (sel < 21) begin
                r = 1'b1; f = 1'b1;
            end else if (sel < 23) begin
                r = 1'b1;
            end else if (sel < 25) begin
                f = 1'b1;
            end
            drive(r, f, lv);
            checks++;
            if (outs() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h expected %h", c, outs(), exp_vec());
            end
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_short();
        test_long();
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
        test_double();
`else
        test_no_double();
`endif
        test_reset_mid_press();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
